// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter in front of the UART TX FIFO
//
// Shares one UART TX FIFO write port between N_REQ byte-stream requesters.
// A requester owns the grant from its first byte until the byte flagged
// last, so packets never interleave. Arbitration is round-robin starting
// from the requester after the previous owner.
//
// Optional feature macro: UART_TX_ARB_WATCHDOG_EN
//   When defined, a stall watchdog revokes the grant after TIMEOUT_CYCLES
//   consecutive active cycles with the grantee's valid low.
//
// Ports:
//   CLK_I        in   clock, rising edge
//   RST_I        in   synchronous active-high reset
//   REQ_VALID_I  in   [N_REQ]    per-requester byte valid
//   REQ_DATA_I   in   [8*N_REQ]  per-requester byte, requester i at [8i+7:8i]
//   REQ_LAST_I   in   [N_REQ]    per-requester last-byte flag
//   REQ_READY_O  out  [N_REQ]    per-requester byte accepted when valid
//   WE_O         out  write strobe to the TX FIFO
//   DSEND_O      out  [8] byte to the TX FIFO
//   TX_READY_I   in   TX FIFO not full
//   GRANT_O      out  [N_REQ]    one-hot grant, zero when idle
//   BUSY_O       out  packet in progress
//   TIMEOUT_O    out  one-cycle pulse when the watchdog revokes a grant

module uart_tx_arbiter #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic [N_REQ-1:0]     REQ_VALID_I,
  input  logic [8*N_REQ-1:0]   REQ_DATA_I,
  input  logic [N_REQ-1:0]     REQ_LAST_I,
  output logic [N_REQ-1:0]     REQ_READY_O,
  output logic                 WE_O,
  output logic [7:0]           DSEND_O,
  input  logic                 TX_READY_I,
  output logic [N_REQ-1:0]     GRANT_O,
  output logic                 BUSY_O,
  output logic                 TIMEOUT_O
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_ptr_nxt;
  logic [PW-1:0]    r_gnt;
  logic [PW-1:0]    w_gnt_nxt;
  logic [PW-1:0]    w_ptr_inc;

  logic [PW-1:0]    w_sel;
  logic [PW-1:0]    w_sel_hi;
  logic [PW-1:0]    w_sel_lo;
  logic             w_found_hi;

  logic             w_active;
  logic             w_valid_g;
  logic             w_last_g;
  logic [7:0]       w_byte;
  logic [N_REQ-1:0] w_gnt_onehot;
  logic             w_xfer;
  logic             w_timeout_hit;

  assign w_active = (r_state == ST_ACTIVE);

  // Round-robin pick: the lowest valid index at or above r_ptr wins; if
  // there is none, wrap around and take the lowest valid index overall.
  // Scanning downward lets the last hit be the lowest index.
  always_comb begin
    w_sel_hi   = '0;
    w_sel_lo   = '0;
    w_found_hi = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (REQ_VALID_I[i]) begin
        w_sel_lo = PW'(i);
        if (PW'(i) >= r_ptr) begin
          w_sel_hi   = PW'(i);
          w_found_hi = 1'b1;
        end
      end
    end
    w_sel = w_found_hi ? w_sel_hi : w_sel_lo;
  end

  // Mux out the granted requester's signals.
  always_comb begin
    w_valid_g    = 1'b0;
    w_last_g     = 1'b0;
    w_byte       = 8'h00;
    w_gnt_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_gnt == PW'(i)) begin
        w_valid_g       = REQ_VALID_I[i];
        w_last_g        = REQ_LAST_I[i];
        w_byte          = REQ_DATA_I[8*i +: 8];
        w_gnt_onehot[i] = 1'b1;
      end
    end
  end

  assign w_ptr_inc = (r_gnt == PW'(N_REQ - 1)) ? '0 : r_gnt + PW'(1);

  // Transfer is purely combinational so a full FIFO is never written.
  assign w_xfer      = w_active & w_valid_g & TX_READY_I;
  assign WE_O        = w_xfer;
  assign DSEND_O     = w_xfer ? w_byte : 8'h00;
  assign GRANT_O     = w_active ? w_gnt_onehot : '0;
  assign REQ_READY_O = (w_active && TX_READY_I) ? w_gnt_onehot : '0;
  assign BUSY_O      = w_active;

`ifdef UART_TX_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_wd_cnt;
  logic          r_timeout;

  // Fires on the stall cycle that brings the count up to TIMEOUT_CYCLES,
  // so the grant drops at that edge and the pulse lines up with IDLE.
  assign w_timeout_hit = w_active && !w_valid_g &&
                         (r_wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_hit;
      if (w_active && !w_valid_g && !w_timeout_hit) begin
        r_wd_cnt <= r_wd_cnt + CW'(1);
      end else begin
        r_wd_cnt <= '0;
      end
    end
  end

  assign TIMEOUT_O = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign TIMEOUT_O     = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (|REQ_VALID_I) begin
          w_state_nxt = ST_ACTIVE;
          w_gnt_nxt   = w_sel;
        end
      end
      ST_ACTIVE: begin
        if ((w_xfer && w_last_g) || w_timeout_hit) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = w_ptr_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   valid = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0]   last = '0;
  logic           tx_ready = 1'b1;
  logic [N-1:0]   ready_o;
  logic           we_o;
  logic [7:0]     dsend_o;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic           timeout_o;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_I(clk), .RST_I(rst),
    .REQ_VALID_I(valid), .REQ_DATA_I(data), .REQ_LAST_I(last),
    .REQ_READY_O(ready_o), .WE_O(we_o), .DSEND_O(dsend_o),
    .TX_READY_I(tx_ready), .GRANT_O(grant_o), .BUSY_O(busy_o),
    .TIMEOUT_O(timeout_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         rst;
    logic [2:0]   v;
    logic [23:0]  d;
    logic [2:0]   l;
    logic         tr;
    logic [2:0]   eg;
    logic         ew;
    logic [7:0]   ed;
    logic [2:0]   er;
    logic         eb;
  } vec_t;

  vec_t tbl[18];

  // Requester sources, FIFO scoreboard and per-cycle samples.
  logic [8:0] src [N][16];
  int         src_wr[N];
  int         src_rd[N];
  logic [N-1:0] hold = '0;
  logic [7:0] sb_q[$];
  logic [N-1:0] s_grant, s_ready;
  logic       s_we, s_busy, s_to;
  logic [7:0] s_d;
  int         nw = 0;
  int         cyc = 0;
  logic [2:0] glog[$];
  int         rv[$];
  int         rl[$];

  task automatic push_pkt(input int r, input logic [7:0] b0, input int n);
    logic [7:0] b;
    for (int j = 0; j < n; j++) begin
      b = b0 + 8'(j);
      src[r][src_wr[r]] = {(j == n - 1), b};
      src_wr[r]++;
    end
  endtask

  task automatic expect_bytes(input logic [7:0] b0, input int n);
    for (int j = 0; j < n; j++) sb_q.push_back(b0 + 8'(j));
  endtask

  task automatic cycle();
    logic [N-1:0] acc;
    for (int i = 0; i < N; i++) begin
      if (src_rd[i] < src_wr[i] && !hold[i]) begin
        valid[i]      = 1'b1;
        data[8*i +: 8] = src[i][src_rd[i]][7:0];
        last[i]       = src[i][src_rd[i]][8];
      end else begin
        valid[i] = 1'b0;
        last[i]  = 1'b0;
      end
    end
    @(negedge clk);
    s_grant = grant_o;
    s_ready = ready_o;
    s_we    = we_o;
    s_busy  = busy_o;
    s_to    = timeout_o;
    s_d     = dsend_o;
    acc     = ready_o & valid;
    chk("we_vs_handshake", 32'(we_o), 32'(|acc));
    if (we_o) begin
      nw++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got %0h want no write", dsend_o);
      end else begin
        chk("fifo_byte", 32'(dsend_o), 32'(sb_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) src_rd[i]++;
    cyc++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    hold = '0;
    sb_q.delete();
    glog.delete();
    tx_ready = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 0;
    nw  = 0;
  endtask

  task automatic drain(input string nm, input int budget);
    int k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      cycle();
      glog.push_back(s_grant);
      k++;
    end
    chk({nm, "_drained"}, sb_q.size(), 0);
    cycle();
    glog.push_back(s_grant);
  endtask

  task automatic build_runs();
    rv.delete();
    rl.delete();
    foreach (glog[i]) begin
      if (rv.size() > 0 && rv[rv.size()-1] == int'(glog[i])) begin
        rl[rl.size()-1] = rl[rl.size()-1] + 1;
      end else begin
        rv.push_back(int'(glog[i]));
        rl.push_back(1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int k;
    int t_last;
    int t_r1;
    int ev[8];
    int el[8];

    //            rst  v       d            l      tr    eg      ew    ed     er      eb
    tbl[0]  = '{1'b1, 3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};
    tbl[1]  = '{1'b0, 3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};
    tbl[2]  = '{1'b0, 3'b011, 24'h00B0A0, 3'b010, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};
    tbl[3]  = '{1'b0, 3'b011, 24'h00B0A0, 3'b010, 1'b1, 3'b001, 1'b1, 8'hA0, 3'b001, 1'b1};
    tbl[4]  = '{1'b0, 3'b011, 24'h00B0A1, 3'b011, 1'b0, 3'b001, 1'b0, 8'h00, 3'b000, 1'b1};
    tbl[5]  = '{1'b0, 3'b011, 24'h00B0A1, 3'b011, 1'b1, 3'b001, 1'b1, 8'hA1, 3'b001, 1'b1};
    tbl[6]  = '{1'b0, 3'b011, 24'h00B0A2, 3'b011, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};
    tbl[7]  = '{1'b0, 3'b011, 24'h00B0A2, 3'b011, 1'b1, 3'b010, 1'b1, 8'hB0, 3'b010, 1'b1};
    tbl[8]  = '{1'b0, 3'b001, 24'h0000A2, 3'b001, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};
    tbl[9]  = '{1'b0, 3'b001, 24'h0000A2, 3'b001, 1'b1, 3'b001, 1'b1, 8'hA2, 3'b001, 1'b1};
    tbl[10] = '{1'b0, 3'b100, 24'hC00000, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};
    tbl[11] = '{1'b0, 3'b000, 24'hC00000, 3'b000, 1'b1, 3'b100, 1'b0, 8'h00, 3'b100, 1'b1};
    tbl[12] = '{1'b1, 3'b100, 24'hC00000, 3'b000, 1'b1, 3'b100, 1'b1, 8'hC0, 3'b100, 1'b1};
    tbl[13] = '{1'b0, 3'b101, 24'hC200D0, 3'b101, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};
    tbl[14] = '{1'b0, 3'b101, 24'hC200D0, 3'b101, 1'b1, 3'b001, 1'b1, 8'hD0, 3'b001, 1'b1};
    tbl[15] = '{1'b0, 3'b100, 24'hC20000, 3'b100, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};
    tbl[16] = '{1'b0, 3'b100, 24'hC20000, 3'b100, 1'b1, 3'b100, 1'b1, 8'hC2, 3'b100, 1'b1};
    tbl[17] = '{1'b0, 3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int v = 0; v < 18; v++) begin
      rst      = tbl[v].rst;
      valid    = tbl[v].v;
      data     = tbl[v].d;
      last     = tbl[v].l;
      tx_ready = tbl[v].tr;
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", v), 32'(grant_o), 32'(tbl[v].eg));
      chk($sformatf("tbl%0d_we", v), 32'(we_o), 32'(tbl[v].ew));
      chk($sformatf("tbl%0d_dsend", v), 32'(dsend_o), 32'(tbl[v].ed));
      chk($sformatf("tbl%0d_ready", v), 32'(ready_o), 32'(tbl[v].er));
      chk($sformatf("tbl%0d_busy", v), 32'(busy_o), 32'(tbl[v].eb));
      chk($sformatf("tbl%0d_timeout", v), 32'(timeout_o), 32'h0);
      @(posedge clk);
      #1;
    end

    // Fairness after reset: two 3-byte packets.
    do_reset();
    push_pkt(0, 8'h10, 3);
    push_pkt(1, 8'h20, 3);
    expect_bytes(8'h10, 3);
    expect_bytes(8'h20, 3);
    drain("fair", 40);
    build_runs();
    ev = '{0, 1, 0, 2, 0, 0, 0, 0};
    el = '{1, 3, 1, 3, 0, 0, 0, 0};
    chk("fair_runs_enough", 32'(rv.size() >= 4), 1);
    for (int j = 0; j < 4; j++) begin
      if (j < rv.size()) begin
        chk($sformatf("fair_run%0d_grant", j), rv[j], ev[j]);
        chk($sformatf("fair_run%0d_len", j), rl[j], el[j]);
      end
    end

    // Round-robin wrap with all three requesters continuously valid.
    do_reset();
    push_pkt(0, 8'h30, 2);
    push_pkt(0, 8'h32, 2);
    push_pkt(1, 8'h40, 2);
    push_pkt(2, 8'h50, 2);
    expect_bytes(8'h30, 2);
    expect_bytes(8'h40, 2);
    expect_bytes(8'h50, 2);
    expect_bytes(8'h32, 2);
    drain("wrap", 60);
    build_runs();
    ev = '{0, 1, 0, 2, 0, 4, 0, 1};
    el = '{1, 2, 1, 2, 1, 2, 1, 2};
    chk("wrap_runs_enough", 32'(rv.size() >= 8), 1);
    for (int j = 0; j < 8; j++) begin
      if (j < rv.size()) begin
        chk($sformatf("wrap_run%0d_grant", j), rv[j], ev[j]);
        chk($sformatf("wrap_run%0d_len", j), rl[j], el[j]);
      end
    end

    // Backpressure for 5 cycles mid-packet.
    do_reset();
    push_pkt(0, 8'h80, 3);
    expect_bytes(8'h80, 3);
    k = 0;
    while (nw < 1 && k < 20) begin cycle(); k++; end
    chk("bp_first_byte", nw, 1);
    tx_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cycle();
      chk($sformatf("bp_we_%0d", j), 32'(s_we), 0);
      chk($sformatf("bp_ready_%0d", j), 32'(s_ready), 0);
      chk($sformatf("bp_grant_%0d", j), 32'(s_grant), 1);
    end
    tx_ready = 1'b1;
    cycle();
    chk("bp_resume_we", 32'(s_we), 1);
    drain("bp", 20);

    // No interleaving while the grantee has random valid gaps.
    do_reset();
    push_pkt(0, 8'h60, 4);
    push_pkt(1, 8'h70, 1);
    expect_bytes(8'h60, 4);
    expect_bytes(8'h70, 1);
    t_last = -1;
    t_r1   = -1;
    k = 0;
    while (sb_q.size() != 0 && k < 100) begin
      hold[0] = (nw > 0 && nw < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      cycle();
      if (s_we && s_d == 8'h63) t_last = cyc;
      if (s_ready[1] && t_r1 < 0) t_r1 = cyc;
      k++;
    end
    hold = '0;
    chk("nil_drained", sb_q.size(), 0);
    chk("nil_ready1_delay", t_r1 - t_last, 2);
    cycle();

    // Reset after byte 2 of 4.
    do_reset();
    push_pkt(0, 8'hE0, 4);
    expect_bytes(8'hE0, 2);
    k = 0;
    while (nw < 2 && k < 20) begin cycle(); k++; end
    chk("rst_two_bytes", nw, 2);
    tx_ready = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    tx_ready = 1'b1;
    src_rd[0] = src_wr[0];
    cycle();
    chk("rst_grant", 32'(s_grant), 0);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_we", 32'(s_we), 0);
    k = nw;
    repeat (4) cycle();
    chk("rst_no_more_writes", nw, k);

    // Stalled grantee: watchdog reclaims, or grant is held without it.
    do_reset();
    push_pkt(0, 8'h90, 3);
    push_pkt(1, 8'hA5, 1);
    expect_bytes(8'h90, 1);
`ifdef UART_TX_ARB_WATCHDOG_EN
    sb_q.push_back(8'hA5);
    expect_bytes(8'h91, 2);
`else
    expect_bytes(8'h91, 2);
    sb_q.push_back(8'hA5);
`endif
    k = 0;
    while (nw < 1 && k < 20) begin cycle(); k++; end
    chk("wd_first_byte", nw, 1);
    hold[0] = 1'b1;
`ifdef UART_TX_ARB_WATCHDOG_EN
    for (int j = 1; j <= 10; j++) begin
      cycle();
      if (j <= 8) begin
        chk($sformatf("wd_busy_%0d", j), 32'(s_busy), 1);
        chk($sformatf("wd_to_%0d", j), 32'(s_to), 0);
      end else if (j == 9) begin
        chk("wd_to_pulse", 32'(s_to), 1);
        chk("wd_idle_grant", 32'(s_grant), 0);
      end else begin
        chk("wd_next_grant", 32'(s_grant), 32'b010);
        chk("wd_to_clear", 32'(s_to), 0);
      end
    end
`else
    for (int j = 0; j < 100; j++) begin
      cycle();
      chk($sformatf("hold_grant_%0d", j), 32'(s_grant), 1);
      chk($sformatf("hold_to_%0d", j), 32'(s_to), 0);
    end
`endif
    hold[0] = 1'b0;
    drain("wd", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
